// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle: register indices and pipeline status in, forward selects and stall/flush controls out.
interface ex_hazard_ctrl_if #(
   parameter int REG_WIDTH = 4
);
   logic [REG_WIDTH-1:0] rsD_i;
   logic [REG_WIDTH-1:0] rtD_i;
   logic                 useRsD_i;
   logic                 useRtD_i;
   logic [REG_WIDTH-1:0] src1E_i;
   logic [REG_WIDTH-1:0] src2E_i;
   logic [REG_WIDTH-1:0] WriteRegE_i;
   logic                 RegWriteE_i;
   logic                 MemReadE_i;
   logic                 FloatingE_i;
   logic [REG_WIDTH-1:0] WriteRegM_i;
   logic                 RegWriteM_i;
   logic [REG_WIDTH-1:0] WriteRegW_i;
   logic                 RegWriteW_i;
   logic                 redirectM_i;
   logic                 mem_wait_i;
   logic [1:0]           alu_src1_o;
   logic [1:0]           alu_src2_o;
   logic                 stall_IF_o;
   logic                 stall_IF_ID_o;
   logic                 stall_ID_EX_o;
   logic                 stall_EX_MEM_o;
   logic                 flush_IF_ID_o;
   logic                 flush_ID_EX_o;
   logic                 flush_EX_MEM_o;
   logic                 fp_busy_o;
   logic                 fp_done_o;

   // Pipeline side: drives stage status, consumes the controls.
   modport master (
      output rsD_i, rtD_i, useRsD_i, useRtD_i, src1E_i, src2E_i,
             WriteRegE_i, RegWriteE_i, MemReadE_i, FloatingE_i,
             WriteRegM_i, RegWriteM_i, WriteRegW_i, RegWriteW_i,
             redirectM_i, mem_wait_i,
      input  alu_src1_o, alu_src2_o, stall_IF_o, stall_IF_ID_o,
             stall_ID_EX_o, stall_EX_MEM_o, flush_IF_ID_o, flush_ID_EX_o,
             flush_EX_MEM_o, fp_busy_o, fp_done_o
   );

   // Controller side.
   modport slave (
      input  rsD_i, rtD_i, useRsD_i, useRtD_i, src1E_i, src2E_i,
             WriteRegE_i, RegWriteE_i, MemReadE_i, FloatingE_i,
             WriteRegM_i, RegWriteM_i, WriteRegW_i, RegWriteW_i,
             redirectM_i, mem_wait_i,
      output alu_src1_o, alu_src2_o, stall_IF_o, stall_IF_ID_o,
             stall_ID_EX_o, stall_EX_MEM_o, flush_IF_ID_o, flush_ID_EX_o,
             flush_EX_MEM_o, fp_busy_o, fp_done_o
   );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stall, multi-cycle FP
// sequencing, data-memory wait and MEM-resolved redirect flushing.
// REG_WIDTH must match the REG_WIDTH of the connected interface.
module ex_hazard_ctrl #(
   parameter int REG_WIDTH = 4,
   parameter int FP_LAT    = 3
) (
   input logic             clk,
   input logic             rst,
   ex_hazard_ctrl_if.slave hz
);
   typedef enum logic {IDLE, RUN} fp_state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FP_LAT - 2);

   fp_state_t state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       fp_stall;
   logic       fp_done;
   logic       ld_haz;
   logic       redirect_eff;

   logic [REG_WIDTH-1:0] rs_d, rt_d, src1_e, src2_e, wr_e, wr_m, wr_w;

   assign rs_d   = hz.rsD_i;
   assign rt_d   = hz.rtD_i;
   assign src1_e = hz.src1E_i;
   assign src2_e = hz.src2E_i;
   assign wr_e   = hz.WriteRegE_i;
   assign wr_m   = hz.WriteRegM_i;
   assign wr_w   = hz.WriteRegW_i;

   // A redirect only counts once the memory stage can actually move.
   assign redirect_eff = hz.redirectM_i && !hz.mem_wait_i;

   assign ld_haz = hz.MemReadE_i && hz.RegWriteE_i &&
                   ((hz.useRsD_i && wr_e == rs_d) || (hz.useRtD_i && wr_e == rt_d));

   // Forward selects: MEM result beats WB result; register 0 is an ordinary register.
   always_comb begin
      hz.alu_src1_o = 2'd0;
      hz.alu_src2_o = 2'd0;
      if (hz.RegWriteM_i && wr_m == src1_e)      hz.alu_src1_o = 2'd1;
      else if (hz.RegWriteW_i && wr_w == src1_e) hz.alu_src1_o = 2'd2;
      if (hz.RegWriteM_i && wr_m == src2_e)      hz.alu_src2_o = 2'd1;
      else if (hz.RegWriteW_i && wr_w == src2_e) hz.alu_src2_o = 2'd2;
   end

   // FP sequencer next state: redirect aborts, memory wait freezes, otherwise count down.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      fp_stall   = 1'b0;
      fp_done    = 1'b0;
      if (redirect_eff) begin
         state_next = IDLE;
         cnt_next   = 4'd0;
      end else if (!hz.mem_wait_i) begin
         case (state)
            IDLE: begin
               if (hz.FloatingE_i) begin
                  fp_stall   = 1'b1;
                  state_next = RUN;
                  cnt_next   = CNT_LOAD;
               end
            end
            RUN: begin
               if (cnt != 4'd0) begin
                  fp_stall = 1'b1;
                  cnt_next = cnt - 4'd1;
               end else begin
                  fp_done    = 1'b1;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end
         endcase
      end
   end

   // FP sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Stall/flush resolution in priority order; everything quiet while in reset.
   always_comb begin
      hz.stall_IF_o     = 1'b0;
      hz.stall_IF_ID_o  = 1'b0;
      hz.stall_ID_EX_o  = 1'b0;
      hz.stall_EX_MEM_o = 1'b0;
      hz.flush_IF_ID_o  = 1'b0;
      hz.flush_ID_EX_o  = 1'b0;
      hz.flush_EX_MEM_o = 1'b0;
      hz.fp_done_o      = fp_done && !rst;
      hz.fp_busy_o      = (state == RUN);
      if (!rst) begin
         if (redirect_eff) begin
            hz.flush_IF_ID_o  = 1'b1;
            hz.flush_ID_EX_o  = 1'b1;
            hz.flush_EX_MEM_o = 1'b1;
         end else if (hz.mem_wait_i) begin
            hz.stall_IF_o     = 1'b1;
            hz.stall_IF_ID_o  = 1'b1;
            hz.stall_ID_EX_o  = 1'b1;
            hz.stall_EX_MEM_o = 1'b1;
         end else if (fp_stall) begin
            hz.stall_IF_o     = 1'b1;
            hz.stall_IF_ID_o  = 1'b1;
            hz.stall_ID_EX_o  = 1'b1;
            hz.flush_EX_MEM_o = 1'b1;
         end else if (ld_haz) begin
            hz.stall_IF_o     = 1'b1;
            hz.stall_IF_ID_o  = 1'b1;
            hz.flush_ID_EX_o  = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl (FP_LAT=3) using an expectation queue.
module tb_ex_hazard_ctrl;
   logic clk;
   logic rst;
   int   tests_run = 0;
   int   failures  = 0;

   typedef struct {
      string      name;
      logic [12:0] val;
   } exp_t;

   exp_t sbq[$];

   ex_hazard_ctrl_if #(.REG_WIDTH(4)) hz ();

   ex_hazard_ctrl #(.REG_WIDTH(4), .FP_LAT(3)) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   logic [12:0] obs;
   assign obs = {hz.alu_src1_o, hz.alu_src2_o,
                 hz.stall_IF_o, hz.stall_IF_ID_o, hz.stall_ID_EX_o, hz.stall_EX_MEM_o,
                 hz.flush_IF_ID_o, hz.flush_ID_EX_o, hz.flush_EX_MEM_o,
                 hz.fp_busy_o, hz.fp_done_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packs an expected output vector: selects, stalls {IF,IF_ID,ID_EX,EX_MEM},
   // flushes {IF_ID,ID_EX,EX_MEM}, busy, done.
   function automatic logic [12:0] mk(logic [1:0] s1, logic [1:0] s2, logic [3:0] st,
                                      logic [2:0] fl, logic b, logic d);
      return {s1, s2, st, fl, b, d};
   endfunction

   task automatic idle_inputs();
      hz.rsD_i       = 4'd0;
      hz.rtD_i       = 4'd0;
      hz.useRsD_i    = 1'b0;
      hz.useRtD_i    = 1'b0;
      hz.src1E_i     = 4'd1;
      hz.src2E_i     = 4'd2;
      hz.WriteRegE_i = 4'd0;
      hz.RegWriteE_i = 1'b0;
      hz.MemReadE_i  = 1'b0;
      hz.FloatingE_i = 1'b0;
      hz.WriteRegM_i = 4'd0;
      hz.RegWriteM_i = 1'b0;
      hz.WriteRegW_i = 4'd0;
      hz.RegWriteW_i = 1'b0;
      hz.redirectM_i = 1'b0;
      hz.mem_wait_i  = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_inputs();
         rst = 1'b1;
         if (i == 0) hz.FloatingE_i = 1'b1;
         else begin
            hz.MemReadE_i = 1'b1; hz.RegWriteE_i = 1'b1;
            hz.WriteRegE_i = 4'd4; hz.rsD_i = 4'd4; hz.useRsD_i = 1'b1;
            hz.redirectM_i = 1'b1;
         end
         sbq.push_back('{$sformatf("reset_c%0d", i), mk(0, 0, 4'b0000, 3'b000, 0, 0)});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
      idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_forwarding();
      exp_t e;
      logic [1:0] s1, s2;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         idle_inputs();
         case (i)
            0: begin
               hz.RegWriteM_i = 1; hz.WriteRegM_i = 5; hz.RegWriteW_i = 1; hz.WriteRegW_i = 5;
               hz.src1E_i = 5; hz.src2E_i = 3;
            end
            1: begin
               hz.RegWriteM_i = 0; hz.WriteRegM_i = 5; hz.RegWriteW_i = 1; hz.WriteRegW_i = 5;
               hz.src1E_i = 5; hz.src2E_i = 3;
            end
            2: begin
               hz.RegWriteM_i = 1; hz.WriteRegM_i = 0; hz.RegWriteW_i = 1; hz.WriteRegW_i = 7;
               hz.src1E_i = 0; hz.src2E_i = 7;
            end
            default: begin
               hz.RegWriteM_i = 1'($urandom_range(0, 1));
               hz.WriteRegM_i = 4'($urandom_range(0, 3));
               hz.RegWriteW_i = 1'($urandom_range(0, 1));
               hz.WriteRegW_i = 4'($urandom_range(0, 3));
               hz.src1E_i     = 4'($urandom_range(0, 3));
               hz.src2E_i     = 4'($urandom_range(0, 3));
            end
         endcase
         s1 = (hz.RegWriteM_i && hz.WriteRegM_i == hz.src1E_i) ? 2'd1 :
              (hz.RegWriteW_i && hz.WriteRegW_i == hz.src1E_i) ? 2'd2 : 2'd0;
         s2 = (hz.RegWriteM_i && hz.WriteRegM_i == hz.src2E_i) ? 2'd1 :
              (hz.RegWriteW_i && hz.WriteRegW_i == hz.src2E_i) ? 2'd2 : 2'd0;
         if (i == 0) begin s1 = 2'd1; s2 = 2'd0; end
         if (i == 1) begin s1 = 2'd2; s2 = 2'd0; end
         if (i == 2) begin s1 = 2'd1; s2 = 2'd2; end
         sbq.push_back('{$sformatf("fwd_c%0d", i), mk(s1, s2, 4'b0000, 3'b000, 0, 0)});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      logic [12:0] tab [9];
      tab = '{mk(0, 0, 4'b1100, 3'b010, 0, 0), mk(0, 0, 4'b0000, 3'b000, 0, 0),
              mk(0, 0, 4'b0000, 3'b000, 0, 0), mk(0, 0, 4'b1100, 3'b010, 0, 0),
              mk(0, 0, 4'b0000, 3'b000, 0, 0), mk(0, 0, 4'b1110, 3'b001, 0, 0),
              mk(0, 0, 4'b1110, 3'b001, 1, 0), mk(0, 0, 4'b0000, 3'b000, 1, 1),
              mk(0, 0, 4'b0000, 3'b000, 0, 0)};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         idle_inputs();
         if (i == 0 || i == 2 || i == 3 || i == 4 || i == 5) begin
            hz.MemReadE_i = 1; hz.RegWriteE_i = 1; hz.WriteRegE_i = 4;
            hz.rsD_i = 4; hz.useRsD_i = 1;
         end
         if (i == 2) hz.useRsD_i = 0;
         if (i == 3) begin hz.useRsD_i = 0; hz.rtD_i = 4; hz.useRtD_i = 1; end
         if (i == 4) hz.RegWriteE_i = 0;
         if (i == 5) hz.FloatingE_i = 1;
         sbq.push_back('{$sformatf("ldu_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_fp();
      exp_t e;
      logic [12:0] tab [4];
      tab = '{mk(0, 0, 4'b1110, 3'b001, 0, 0), mk(0, 0, 4'b1110, 3'b001, 1, 0),
              mk(0, 0, 4'b0000, 3'b000, 1, 1), mk(0, 0, 4'b0000, 3'b000, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         hz.FloatingE_i = (i < 3);
         sbq.push_back('{$sformatf("fp_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [12:0] tab [7];
      tab = '{mk(0, 0, 4'b1110, 3'b001, 0, 0), mk(0, 0, 4'b1110, 3'b001, 1, 0),
              mk(0, 0, 4'b0000, 3'b000, 1, 1), mk(0, 0, 4'b1110, 3'b001, 0, 0),
              mk(0, 0, 4'b1110, 3'b001, 1, 0), mk(0, 0, 4'b0000, 3'b000, 1, 1),
              mk(0, 0, 4'b0000, 3'b000, 0, 0)};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         idle_inputs();
         hz.FloatingE_i = (i < 6);
         sbq.push_back('{$sformatf("b2b_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_fp_mem_wait();
      exp_t e;
      logic [12:0] tab [6];
      tab = '{mk(0, 0, 4'b1110, 3'b001, 0, 0), mk(0, 0, 4'b1111, 3'b000, 1, 0),
              mk(0, 0, 4'b1110, 3'b001, 1, 0), mk(0, 0, 4'b0000, 3'b000, 1, 1),
              mk(0, 0, 4'b0000, 3'b000, 0, 0), mk(0, 0, 4'b1111, 3'b000, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle_inputs();
         hz.FloatingE_i = (i < 4);
         hz.mem_wait_i  = (i == 1 || i == 5);
         sbq.push_back('{$sformatf("mwait_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_redirect_abort();
      exp_t e;
      logic [12:0] tab [6];
      tab = '{mk(0, 0, 4'b1110, 3'b001, 0, 0), mk(0, 0, 4'b0000, 3'b111, 1, 0),
              mk(0, 0, 4'b0000, 3'b000, 0, 0), mk(0, 0, 4'b1111, 3'b000, 0, 0),
              mk(0, 0, 4'b0000, 3'b111, 0, 0), mk(0, 0, 4'b0000, 3'b000, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle_inputs();
         hz.FloatingE_i = (i < 2);
         hz.redirectM_i = (i == 1 || i == 3 || i == 4);
         hz.mem_wait_i  = (i == 3);
         sbq.push_back('{$sformatf("redir_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      logic [12:0] tab [4];
      tab = '{mk(0, 0, 4'b1110, 3'b001, 0, 0), mk(0, 0, 4'b0000, 3'b000, 1, 0),
              mk(0, 0, 4'b0000, 3'b000, 0, 0), mk(0, 0, 4'b0000, 3'b000, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         rst = (i == 1);
         hz.FloatingE_i = (i < 2);
         sbq.push_back('{$sformatf("rstrun_c%0d", i), tab[i]});
         #2;
         e = sbq.pop_front();
         tests_run++;
         if (obs !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_fp();
      test_back_to_back();
      test_fp_mem_wait();
      test_redirect_abort();
      test_reset_mid_run();
      tests_run++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard controller for the 16-bit 5-stage core. It generates the EX-stage operand forwarding selects and all IF/ID, ID/EX and EX/MEM stall/flush controls. It sequences multi-cycle floating-point operations in EX with a counter FSM, and also handles load-use stalls, data-memory wait and branch/jump redirect resolved in MEM.

Parameters:
REG_WIDTH, 4, register index width
FP_LAT, 3, total EX occupancy in cycles of a floating-point op (legal range 2..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rsD_i  in  REG_WIDTH  ID-stage source reg 1
rtD_i  in  REG_WIDTH  ID-stage source reg 2
useRsD_i  in  1  ID instruction reads rsD
useRtD_i  in  1  ID instruction reads rtD
src1E_i  in  REG_WIDTH  EX operand-1 source reg
src2E_i  in  REG_WIDTH  EX operand-2 source reg
WriteRegE_i  in  REG_WIDTH  EX destination reg
RegWriteE_i  in  1  EX writes RF
MemReadE_i  in  1  EX is a load
FloatingE_i  in  1  EX is a floating-point op
WriteRegM_i  in  REG_WIDTH  MEM destination reg
RegWriteM_i  in  1  MEM writes RF
WriteRegW_i  in  REG_WIDTH  WB destination reg
RegWriteW_i  in  1  WB writes RF
redirectM_i  in  1  taken branch or jump in MEM
mem_wait_i  in  1  data memory not ready
alu_src1_o  out  2  operand-1 select: 0 RF, 1 MEM fwd, 2 WB fwd
alu_src2_o  out  2  operand-2 select, same encoding
stall_IF_o  out  1  hold PC
stall_IF_ID_o  out  1  hold IF/ID
stall_ID_EX_o  out  1  hold ID/EX
stall_EX_MEM_o  out  1  hold EX/MEM
flush_IF_ID_o  out  1  bubble IF/ID
flush_ID_EX_o  out  1  bubble ID/EX
flush_EX_MEM_o  out  1  bubble EX/MEM
fp_busy_o  out  1  FP sequence in progress
fp_done_o  out  1  one-cycle pulse, FP release cycle

Behaviour:
- Forwarding (combinational): alu_src1_o=1 if RegWriteM_i && WriteRegM_i==src1E_i; else 2 if RegWriteW_i && WriteRegW_i==src1E_i; else 0. MEM has priority over WB. alu_src2_o uses the same rule with src2E_i. There is no hardwired zero register.
- Load-use (ld_haz): MemReadE_i && RegWriteE_i && ((useRsD_i && WriteRegE_i==rsD_i) || (useRtD_i && WriteRegE_i==rtD_i)).
- FP FSM states: IDLE, RUN. 4-bit counter cnt.
  - IDLE: if FloatingE_i && !redirect_eff && !mem_wait_i, assert fp_stall, load cnt<=FP_LAT-2, go to RUN.
  - RUN: if cnt!=0, assert fp_stall and decrement cnt. If cnt==0, deassert fp_stall, pulse fp_done_o, go to IDLE.
  - The FP op therefore occupies EX for exactly FP_LAT cycles, and EX/MEM captures in the last of them.
  - fp_busy_o = (state==RUN).
- redirect_eff = redirectM_i && !mem_wait_i.
- Control priority, highest first:
  1. redirect_eff: flush_IF_ID_o = flush_ID_EX_o = flush_EX_MEM_o = 1, all stalls 0. The FSM is forced to IDLE and cnt cleared, which aborts any FP op.
  2. mem_wait_i: all four stalls = 1, all flushes 0. FSM state and cnt are frozen.
  3. fp_stall: stall_IF_o, stall_IF_ID_o and stall_ID_EX_o = 1; flush_EX_MEM_o = 1, so a bubble goes to MEM each stalled cycle.
  4. ld_haz: stall_IF_o and stall_IF_ID_o = 1; flush_ID_EX_o = 1. Single cycle, re-evaluated every cycle.
  5. Otherwise all stall and flush outputs are 0.
- Forward selects are independent of this priority.
- Reset: state=IDLE, cnt=0, fp_busy_o=0, fp_done_o=0. With rst high, all stall and flush outputs are 0.
- Reset asserted mid-RUN returns the FSM to IDLE on the next edge with no fp_done_o pulse.
- Back-to-back FP ops: an FP op in EX in the cycle after release re-enters RUN normally, with no idle gap required.

Test Plan:
- Forwarding: RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, src1E=5, src2E=3 -> alu_src1_o=1, alu_src2_o=0. Then set RegWriteM=0 -> alu_src1_o=2.
- Load-use: MemReadE=RegWriteE=1, WriteRegE=4, rsD=4, useRsD=1 for one cycle -> stall_IF_o, stall_IF_ID_o and flush_ID_EX_o high for exactly that cycle. Repeat with useRsD=0 -> no stall.
- FP op, FP_LAT=3, FloatingE high from cycle t:
  - cycles t and t+1: stalls high, flush_EX_MEM_o high.
  - cycle t+2: no stall, fp_done_o=1.
  - fp_busy_o high in cycles t+1..t+2.
- FP with mem_wait: mem_wait_i=1 in cycle t+1 -> all four stalls high and cnt frozen; release moves to cycle t+3.
- Redirect abort: redirectM_i=1 in cycle t+1 of an FP op -> all three flushes high, no stalls, FSM returns to IDLE, no fp_done_o pulse.
- Reset: rst in cycle t+1 of an FP op -> next cycle fp_busy_o=0, all outputs 0, no fp_done_o.
